qa_drv_hc_fifo_from_host_mc: RTL and testbench

- Multi-channel successor to the single-ring host-to-FPGA FIFO reader in the host-channels layer.
- Reads cache lines from N_CHANNELS independent host ring buffers.
- Arbitrates read requests round-robin onto one memory read port and reorders out-of-order responses in a shared scoreboard.
- Delivers lines to per-channel FPGA-side consumers in per-channel order and reports a per-channel consumed pointer so the status manager can return ring credit to the host.

---
 rtl/qa_drv_hc_fifo_from_host_mc.sv | 200 ++++++++++++++++++++
 tb/tb_qa_drv_hc_fifo_from_host_mc.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qa_drv_hc_fifo_from_host_mc.sv
// Multi-channel host ring reader: round-robin read request arbitration onto one memory port,
// shared reorder scoreboard, and in-order per-channel delivery with consumed-pointer reporting.
module qa_drv_hc_fifo_from_host_mc #(
    parameter int unsigned N_CHANNELS      = 4,
    parameter int unsigned IDX_BITS        = 9,
    parameter int unsigned ADDR_BITS       = 32,
    parameter int unsigned DATA_BITS       = 512,
    parameter int unsigned N_SB_ENTRIES    = 64,
    parameter int unsigned MAX_OUTSTANDING = 16,
    localparam int unsigned TAG_BITS       = $clog2(N_SB_ENTRIES)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [N_CHANNELS-1:0]           chan_en,
    input  logic [N_CHANNELS*ADDR_BITS-1:0] buf_base,
    input  logic [N_CHANNELS*IDX_BITS-1:0]  newest_idx,
    output logic [N_CHANNELS*IDX_BITS-1:0]  oldest_idx,
    output logic                            rd_req_valid,
    output logic [ADDR_BITS-1:0]            rd_req_addr,
    output logic [TAG_BITS-1:0]             rd_req_tag,
    input  logic                            rd_req_grant,
    input  logic                            rd_rsp_valid,
    input  logic [TAG_BITS-1:0]             rd_rsp_tag,
    input  logic [DATA_BITS-1:0]            rd_rsp_data,
    output logic [N_CHANNELS-1:0]           out_valid,
    output logic [DATA_BITS-1:0]            out_data,
    input  logic [N_CHANNELS-1:0]           out_ready,
    output logic                            err_sticky
);
    localparam int unsigned CH_BITS  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int unsigned OUT_BITS = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CNT_BITS = TAG_BITS + 1;

    typedef logic [CH_BITS-1:0]  ch_t;
    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [OUT_BITS-1:0] out_t;

    idx_t                  next_req_q [N_CHANNELS];
    idx_t                  next_req_d [N_CHANNELS];
    idx_t                  oldest_q   [N_CHANNELS];
    idx_t                  oldest_d   [N_CHANNELS];
    out_t                  outst_q    [N_CHANNELS];
    out_t                  outst_d    [N_CHANNELS];
    ch_t                   rr_q, rr_d;
    logic                  req_valid_q, req_valid_d;
    ch_t                   req_chan_q, req_chan_d;
    logic [ADDR_BITS-1:0]  req_addr_q, req_addr_d;
    logic [TAG_BITS-1:0]   req_tag_q, req_tag_d;
    logic [TAG_BITS-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic [N_SB_ENTRIES-1:0] sb_alloc_q, sb_alloc_d, sb_valid_q, sb_valid_d;
    ch_t                   sb_chan_q [N_SB_ENTRIES];
    ch_t                   sb_chan_d [N_SB_ENTRIES];
    logic [DATA_BITS-1:0]  sb_data_q [N_SB_ENTRIES];
    logic                  err_q, err_d;

    logic                  grant_ok, deliver, head_valid, rsp_ok, full_d;
    ch_t                   head_chan, sel_hi, sel_lo, sel;
    logic                  found_hi, found_lo;
    logic [N_CHANNELS-1:0] eligible;

    always_comb begin
        grant_ok   = rd_req_grant && req_valid_q;
        head_valid = sb_valid_q[head_q];
        head_chan  = sb_chan_q[head_q];
        deliver    = head_valid && out_ready[head_chan];
        rsp_ok     = rd_rsp_valid && sb_alloc_q[rd_rsp_tag] && !sb_valid_q[rd_rsp_tag];
    end

    // Pointer, counter and scoreboard bookkeeping
    always_comb begin
        next_req_d = next_req_q;
        oldest_d   = oldest_q;
        outst_d    = outst_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        sb_alloc_d = sb_alloc_q;
        sb_valid_d = sb_valid_q;
        sb_chan_d  = sb_chan_q;
        rr_d       = rr_q;
        err_d      = err_q | (rd_req_grant && !req_valid_q) | (rd_rsp_valid && !rsp_ok);
        for (int c = 0; c < int'(N_CHANNELS); c++) begin
            logic inc, dec;
            inc = grant_ok && (req_chan_q == ch_t'(c));
            dec = deliver && (head_chan == ch_t'(c));
            if (inc) next_req_d[c] = next_req_q[c] + idx_t'(1);
            if (dec) oldest_d[c] = oldest_q[c] + idx_t'(1);
            if (inc && !dec) outst_d[c] = outst_q[c] + out_t'(1);
            else if (dec && !inc) outst_d[c] = outst_q[c] - out_t'(1);
        end
        if (grant_ok && !deliver) count_d = count_q + CNT_BITS'(1);
        else if (deliver && !grant_ok) count_d = count_q - CNT_BITS'(1);
        if (deliver) begin
            sb_alloc_d[head_q] = 1'b0;
            sb_valid_d[head_q] = 1'b0;
            head_d             = head_q + TAG_BITS'(1);
        end
        if (grant_ok) begin
            sb_alloc_d[tail_q] = 1'b1;
            sb_valid_d[tail_q] = 1'b0;
            sb_chan_d[tail_q]  = req_chan_q;
            tail_d             = tail_q + TAG_BITS'(1);
            rr_d = (req_chan_q == ch_t'(N_CHANNELS - 1)) ? '0 : req_chan_q + ch_t'(1);
        end
        if (rsp_ok) sb_valid_d[rd_rsp_tag] = 1'b1;
    end

    // Eligibility uses post-update state so a request can be reloaded in the grant cycle
    always_comb begin
        full_d   = count_d >= CNT_BITS'(N_SB_ENTRIES);
        eligible = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int c = 0; c < int'(N_CHANNELS); c++) begin
            eligible[c] = chan_en[c] && (next_req_d[c] != newest_idx[c*IDX_BITS +: IDX_BITS]) &&
                          (outst_d[c] < out_t'(MAX_OUTSTANDING)) && !full_d;
        end
        for (int c = int'(N_CHANNELS) - 1; c >= 0; c--) begin
            if (eligible[c]) begin
                found_lo = 1'b1;
                sel_lo   = ch_t'(c);
                if (c >= int'(rr_d)) begin
                    found_hi = 1'b1;
                    sel_hi   = ch_t'(c);
                end
            end
        end
        sel = found_hi ? sel_hi : sel_lo;

        req_valid_d = req_valid_q && !grant_ok;
        req_chan_d  = req_chan_q;
        req_addr_d  = req_addr_q;
        req_tag_d   = req_tag_q;
        if ((!req_valid_q || grant_ok) && found_lo) begin
            req_valid_d = 1'b1;
            req_chan_d  = sel;
            req_addr_d  = buf_base[sel*ADDR_BITS +: ADDR_BITS] + ADDR_BITS'(next_req_d[sel]);
            req_tag_d   = tail_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_req_q  <= '{default: '0};
            oldest_q    <= '{default: '0};
            outst_q     <= '{default: '0};
            rr_q        <= '0;
            req_valid_q <= 1'b0;
            req_chan_q  <= '0;
            req_addr_q  <= '0;
            req_tag_q   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            sb_alloc_q  <= '0;
            sb_valid_q  <= '0;
            sb_chan_q   <= '{default: '0};
            err_q       <= 1'b0;
        end else begin
            next_req_q  <= next_req_d;
            oldest_q    <= oldest_d;
            outst_q     <= outst_d;
            rr_q        <= rr_d;
            req_valid_q <= req_valid_d;
            req_chan_q  <= req_chan_d;
            req_addr_q  <= req_addr_d;
            req_tag_q   <= req_tag_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            sb_alloc_q  <= sb_alloc_d;
            sb_valid_q  <= sb_valid_d;
            sb_chan_q   <= sb_chan_d;
            err_q       <= err_d;
        end
    end

    // Line storage carries no reset; validity is tracked by sb_valid_q
    always_ff @(posedge clk) begin
        if (rsp_ok) sb_data_q[rd_rsp_tag] <= rd_rsp_data;
    end

    always_comb begin
        oldest_idx = '0;
        for (int c = 0; c < int'(N_CHANNELS); c++) begin
            oldest_idx[c*IDX_BITS +: IDX_BITS] = oldest_q[c];
        end
        out_valid = '0;
        if (head_valid) out_valid[head_chan] = 1'b1;
        out_data     = sb_data_q[head_q];
        rd_req_valid = req_valid_q;
        rd_req_addr  = req_addr_q;
        rd_req_tag   = req_tag_q;
        err_sticky   = err_q;
    end

endmodule

// File: tb/tb_qa_drv_hc_fifo_from_host_mc.sv
// Directed self-checking bench for qa_drv_hc_fifo_from_host_mc (4 channels, small scoreboard,
// per-channel cap of 2) with a negedge memory responder for the streaming scenarios.
module tb_qa_drv_hc_fifo_from_host_mc;
    localparam int unsigned NCH  = 4;
    localparam int unsigned IDXB = 9;
    localparam int unsigned AB   = 32;
    localparam int unsigned DB   = 32;
    localparam int unsigned NSB  = 16;
    localparam int unsigned MAXO = 2;
    localparam int unsigned TGB  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic [NCH-1:0]       chan_en;
    logic [NCH*AB-1:0]    buf_base;
    logic [NCH*IDXB-1:0]  newest_idx;
    logic [NCH*IDXB-1:0]  oldest_idx;
    logic                 rd_req_valid;
    logic [AB-1:0]        rd_req_addr;
    logic [TGB-1:0]       rd_req_tag;
    logic                 rd_req_grant;
    logic                 rd_rsp_valid;
    logic [TGB-1:0]       rd_rsp_tag;
    logic [DB-1:0]        rd_rsp_data;
    logic [NCH-1:0]       out_valid;
    logic [DB-1:0]        out_data;
    logic [NCH-1:0]       out_ready;
    logic                 err_sticky;

    logic                 auto_rsp = 1'b0;
    logic                 a_valid  = 1'b0;
    logic [TGB-1:0]       a_tag    = '0;
    logic [DB-1:0]        a_data   = '0;
    logic                 m_valid;
    logic [TGB-1:0]       m_tag;
    logic [DB-1:0]        m_data;

    assign rd_rsp_valid = auto_rsp ? a_valid : m_valid;
    assign rd_rsp_tag   = auto_rsp ? a_tag   : m_tag;
    assign rd_rsp_data  = auto_rsp ? a_data  : m_data;

    int total = 0;
    int bad   = 0;

    qa_drv_hc_fifo_from_host_mc #(
        .N_CHANNELS     (NCH),
        .IDX_BITS       (IDXB),
        .ADDR_BITS      (AB),
        .DATA_BITS      (DB),
        .N_SB_ENTRIES   (NSB),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chan_en     (chan_en),
        .buf_base    (buf_base),
        .newest_idx  (newest_idx),
        .oldest_idx  (oldest_idx),
        .rd_req_valid(rd_req_valid),
        .rd_req_addr (rd_req_addr),
        .rd_req_tag  (rd_req_tag),
        .rd_req_grant(rd_req_grant),
        .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_tag  (rd_rsp_tag),
        .rd_rsp_data (rd_rsp_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .err_sticky  (err_sticky)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_C3C3;
    endfunction

    // Address of tag k in the 4-channel round-robin scenario
    function automatic logic [31:0] addr_of_tag(input int k);
        return 32'h1000 + 32'(k % 4) * 32'h100 + 32'(k / 4);
    endfunction

    // Memory model: answers each granted request one cycle after the grant, in order
    logic [TGB-1:0] pq_tag[$];
    logic [31:0]    pq_addr[$];
    always @(negedge clk) begin
        if (!auto_rsp || !reset_n) begin
            pq_tag.delete();
            pq_addr.delete();
            a_valid <= 1'b0;
        end else begin
            if (pq_tag.size() > 0) begin
                a_valid <= 1'b1;
                a_tag   <= pq_tag.pop_front();
                a_data  <= data_of(pq_addr.pop_front());
            end else begin
                a_valid <= 1'b0;
            end
            if (rd_req_valid && rd_req_grant) begin
                pq_tag.push_back(rd_req_tag);
                pq_addr.push_back(rd_req_addr);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        chan_en      = '0;
        buf_base     = '0;
        newest_idx   = '0;
        rd_req_grant = 1'b0;
        m_valid      = 1'b0;
        m_tag        = '0;
        m_data       = '0;
        out_ready    = '0;
        auto_rsp     = 1'b0;
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        #3;
        total++; if (rd_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b expected 0", rd_req_valid); end
        total++; if (out_valid !== '0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (oldest_idx !== '0) begin bad++; $display("FAIL reset_oldest: got %h expected 0", oldest_idx); end
        total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err_sticky); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        total++; if (rd_req_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_req: got %b expected 0", rd_req_valid); end
    endtask

    task automatic test_single_channel();
        int n_req = 0;
        int n_del = 0;
        reset_dut();
        buf_base[0 +: AB]     = 32'h1000;
        newest_idx[0 +: IDXB] = 9'd3;
        chan_en   = 4'b0001;
        out_ready = 4'hF;
        auto_rsp  = 1'b1;
        repeat (40) begin
            tick();
            if (out_valid[3:1] !== 3'b000) begin
                total++; bad++; $display("FAIL single_other_valid: got %b expected 000", out_valid[3:1]);
            end
            if (out_valid[0]) begin
                total++;
                if (out_data !== data_of(32'h1000 + 32'(n_del))) begin
                    bad++; $display("FAIL single_data%0d: got %h expected %h", n_del, out_data,
                                    data_of(32'h1000 + 32'(n_del)));
                end
                n_del++;
            end
            if (rd_req_valid) begin
                total++;
                if (rd_req_addr !== 32'h1000 + 32'(n_req)) begin
                    bad++; $display("FAIL single_addr%0d: got %h expected %h", n_req, rd_req_addr,
                                    32'h1000 + 32'(n_req));
                end
                n_req++;
            end
            rd_req_grant = rd_req_valid;
        end
        rd_req_grant = 1'b0;
        total++; if (n_req != 3) begin bad++; $display("FAIL single_nreq: got %0d expected 3", n_req); end
        total++; if (n_del != 3) begin bad++; $display("FAIL single_ndel: got %0d expected 3", n_del); end
        total++; if (oldest_idx[0 +: IDXB] !== 9'd3) begin bad++; $display("FAIL single_oldest: got %0d expected 3", oldest_idx[0 +: IDXB]); end
        total++; if (rd_req_valid !== 1'b0) begin bad++; $display("FAIL single_req_falls: got %b expected 0", rd_req_valid); end
    endtask

    task automatic test_round_robin();
        int n = 0;
        reset_dut();
        for (int c = 0; c < 4; c++) begin
            buf_base[c*AB +: AB]     = 32'h1000 + 32'(c) * 32'h100;
            newest_idx[c*IDXB +: IDXB] = 9'd2;
        end
        chan_en = 4'hF;
        repeat (20) begin
            tick();
            if (rd_req_valid) begin
                if (n >= 8) begin
                    total++; bad++; $display("FAIL rr_extra: got request %0d expected none", n);
                end else begin
                    total++;
                    if (rd_req_addr !== addr_of_tag(n)) begin
                        bad++; $display("FAIL rr_addr%0d: got %h expected %h", n, rd_req_addr, addr_of_tag(n));
                    end
                    total++;
                    if (rd_req_tag !== 4'(n)) begin
                        bad++; $display("FAIL rr_tag%0d: got %0d expected %0d", n, rd_req_tag, n);
                    end
                end
                n++;
            end
            rd_req_grant = rd_req_valid;
        end
        rd_req_grant = 1'b0;
        total++; if (n != 8) begin bad++; $display("FAIL rr_count: got %0d expected 8", n); end
        total++; if (rd_req_valid !== 1'b0) begin bad++; $display("FAIL rr_idle: got %b expected 0", rd_req_valid); end
    endtask

    // Relies on the eight undelivered lines left by test_round_robin
    task automatic test_reorder();
        int ord [4] = '{3, 1, 2, 0};
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            m_valid = 1'b1;
            m_tag   = 4'(ord[i]);
            m_data  = data_of(addr_of_tag(ord[i]));
            tick();
            if (i < 3) begin
                total++;
                if (out_valid !== 4'b0000) begin bad++; $display("FAIL reorder_hold%0d: got %b expected 0000", i, out_valid); end
            end
        end
        m_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] exp_v;
            exp_v = 4'b0001 << k;
            total++; if (out_valid !== exp_v) begin bad++; $display("FAIL reorder_valid%0d: got %b expected %b", k, out_valid, exp_v); end
            total++; if (out_data !== data_of(addr_of_tag(k))) begin bad++; $display("FAIL reorder_data%0d: got %h expected %h", k, out_data, data_of(addr_of_tag(k))); end
            tick();
        end
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL reorder_after: got %b expected 0000", out_valid); end
        total++; if (oldest_idx !== {4{9'd1}}) begin bad++; $display("FAIL reorder_oldest: got %h expected %h", oldest_idx, {4{9'd1}}); end
        out_ready = '0;
    endtask

    task automatic test_wrap();
        int cyc = 0;
        int n = 0;
        int d = 0;
        logic saw_wrap = 1'b0;
        logic [8:0] prev, cur;
        logic [31:0] exp_a;
        reset_dut();
        buf_base[0 +: AB]     = 32'h2000;
        newest_idx[0 +: IDXB] = 9'd511;
        chan_en   = 4'b0001;
        out_ready = 4'b0001;
        auto_rsp  = 1'b1;
        while (oldest_idx[0 +: IDXB] !== 9'd511 && cyc < 4000) begin
            tick();
            rd_req_grant = rd_req_valid;
            cyc++;
        end
        total++; if (cyc >= 4000) begin bad++; $display("FAIL wrap_ffwd_timeout: got oldest %0d expected 511", oldest_idx[0 +: IDXB]); end
        total++; if (rd_req_valid !== 1'b0) begin bad++; $display("FAIL wrap_idle: got %b expected 0", rd_req_valid); end
        newest_idx[0 +: IDXB] = 9'd1;
        prev = 9'd511;
        repeat (30) begin
            tick();
            cur = oldest_idx[0 +: IDXB];
            if (prev == 9'd511 && cur == 9'd0) saw_wrap = 1'b1;
            prev = cur;
            if (out_valid[0]) begin
                exp_a = (d == 0) ? 32'h21FF : 32'h2000;
                total++; if (out_data !== data_of(exp_a)) begin bad++; $display("FAIL wrap_data%0d: got %h expected %h", d, out_data, data_of(exp_a)); end
                d++;
            end
            if (rd_req_valid) begin
                exp_a = (n == 0) ? 32'h21FF : 32'h2000;
                total++;
                if (n >= 2) begin bad++; $display("FAIL wrap_extra: got addr %h expected none", rd_req_addr); end
                else if (rd_req_addr !== exp_a) begin bad++; $display("FAIL wrap_addr%0d: got %h expected %h", n, rd_req_addr, exp_a); end
                n++;
            end
            rd_req_grant = rd_req_valid;
        end
        rd_req_grant = 1'b0;
        total++; if (n != 2) begin bad++; $display("FAIL wrap_nreq: got %0d expected 2", n); end
        total++; if (saw_wrap !== 1'b1) begin bad++; $display("FAIL wrap_oldest_wrap: got %b expected 1", saw_wrap); end
        total++; if (oldest_idx[0 +: IDXB] !== 9'd1) begin bad++; $display("FAIL wrap_oldest: got %0d expected 1", oldest_idx[0 +: IDXB]); end
    endtask

    task automatic test_max_outstanding();
        int n = 0;
        reset_dut();
        buf_base[0 +: AB]     = 32'h3000;
        newest_idx[0 +: IDXB] = 9'd5;
        chan_en  = 4'b0001;
        auto_rsp = 1'b1;
        repeat (12) begin
            tick();
            if (rd_req_valid) n++;
            rd_req_grant = rd_req_valid;
        end
        rd_req_grant = 1'b0;
        total++; if (n != 2) begin bad++; $display("FAIL maxo_grants: got %0d expected 2", n); end
        total++; if (rd_req_valid !== 1'b0) begin bad++; $display("FAIL maxo_blocked: got %b expected 0", rd_req_valid); end
        total++; if (out_valid !== 4'b0001) begin bad++; $display("FAIL maxo_head: got %b expected 0001", out_valid); end
        out_ready = 4'b0001;
        tick();
        out_ready = 4'b0000;
        total++; if (rd_req_valid !== 1'b1) begin bad++; $display("FAIL maxo_third_valid: got %b expected 1", rd_req_valid); end
        total++; if (rd_req_addr !== 32'h3002) begin bad++; $display("FAIL maxo_third_addr: got %h expected 00003002", rd_req_addr); end
        total++; if (oldest_idx[0 +: IDXB] !== 9'd1) begin bad++; $display("FAIL maxo_oldest: got %0d expected 1", oldest_idx[0 +: IDXB]); end
    endtask

    task automatic test_errors();
        reset_dut();
        m_valid = 1'b1;
        m_tag   = 4'd5;
        m_data  = 32'hDEAD_BEEF;
        tick();
        m_valid = 1'b0;
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL err_unalloc: got %b expected 1", err_sticky); end
        tick();
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL err_no_valid: got %b expected 0000", out_valid); end
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL err_sticks: got %b expected 1", err_sticky); end
        reset_dut();
        total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b expected 0", err_sticky); end
        rd_req_grant = 1'b1;
        tick();
        rd_req_grant = 1'b0;
        total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL err_spurious_grant: got %b expected 1", err_sticky); end
        for (int c = 0; c < 4; c++) begin
            buf_base[c*AB +: AB]       = 32'h1000 + 32'(c) * 32'h100;
            newest_idx[c*IDXB +: IDXB] = 9'd3;
        end
        chan_en   = 4'hF;
        out_ready = 4'hF;
        auto_rsp  = 1'b1;
        repeat (15) begin
            tick();
            rd_req_grant = rd_req_valid;
        end
        total++; if (oldest_idx === '0) begin bad++; $display("FAIL err_traffic: got oldest %h expected nonzero", oldest_idx); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (rd_req_valid !== 1'b0) begin bad++; $display("FAIL areset_req: got %b expected 0", rd_req_valid); end
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL areset_out_valid: got %b expected 0000", out_valid); end
        total++; if (oldest_idx !== '0) begin bad++; $display("FAIL areset_oldest: got %h expected 0", oldest_idx); end
        total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL areset_err: got %b expected 0", err_sticky); end
        drive_idle();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_reorder();
        test_wrap();
        test_max_outstanding();
        test_errors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
